// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
// Shared types and constants for the shared-divider controller.
//   state_t   : controller FSM states (IDLE / BUSY / RESP)
//   DW        : datapath width of the divider
//   MOST_NEG  : most negative two's complement value (overflow screen)
//   MINUS_ONE : all-ones divisor (overflow screen)
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          DW        = 32;
    localparam logic [31:0] MOST_NEG  = 32'h8000_0000;
    localparam logic [31:0] MINUS_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/Divider32bit.sv
// Divider32bit
// Combinational 32-bit signed divider. Quotient truncates toward zero,
// remainder takes the sign of the dividend.
//   a   : signed dividend
//   b   : signed divisor
//   y   : {remainder, quotient}
//   err : divide-by-zero or signed overflow
module Divider32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] y,
    output logic        err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        if (b == 32'd0) begin
            err = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            err       = 1'b1;
            y[31:0]   = 32'h8000_0000;
        end else begin
            y[31:0]   = $signed(a) / $signed(b);
            y[63:32]  = $signed(a) % $signed(b);
        end
    end

endmodule

// File: rtl/div_rr_arbiter.sv
// div_rr_arbiter
// Round-robin arbiter: grants the first asserted request at or above the
// pointer rr, wrapping to index 0.
//   req : request vector
//   rr  : round-robin pointer (highest-priority index)
//   en  : grant enable; no grant when low
//   gnt : one-hot grant
//   idx : encoded index of the granted request
module div_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  rr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // First pass: indices from rr upward.
        for (int k = 0; k < NREQ; k++) begin
            if (!found && en && req[k] && k >= int'(rr)) begin
                gnt[k] = 1'b1;
                idx    = IDW'(k);
                found  = 1'b1;
            end
        end
        // Second pass: wrap around to indices below rr.
        for (int k = 0; k < NREQ; k++) begin
            if (!found && en && req[k] && k < int'(rr)) begin
                gnt[k] = 1'b1;
                idx    = IDW'(k);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl
// Shares one combinational signed divider among NREQ requesters. Grants
// round-robin, holds operands for LAT settle cycles, screens divide-by-zero
// and overflow up front, and returns an ID-tagged response.
//   clk, reset                : clock, async active-high reset
//   req_valid / req_ready     : per-requester handshake (req_ready combinational)
//   req_dividend / req_divisor: packed operands, requester i at [32i+31:32i]
//   rsp_valid / rsp_ready     : response handshake
//   rsp_id, rsp_quotient, rsp_remainder, rsp_error : registered response
//
// state | meaning
// IDLE  | arbitrate and accept one request
// BUSY  | operands held on the divider for LAT cycles
// RESP  | response presented until rsp_ready
module div_share_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LAT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DW-1:0]       req_dividend,
    input  logic [NREQ*DW-1:0]       req_divisor,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DW-1:0]            rsp_quotient,
    output logic [DW-1:0]            rsp_remainder,
    output logic                     rsp_error
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

    state_t          state;
    logic [IDW-1:0]  rr;
    logic [IDW-1:0]  op_id;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic [DW-1:0]   sel_a;
    logic [DW-1:0]   sel_b;
    logic [2*DW-1:0] div_y;
    logic            div_error_unused;
    logic            accept;

    // Reset also gates the grant so req_ready reads zero while reset is held.
    div_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .rr  (rr),
        .en  (state == IDLE && !reset),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign sel_a     = req_dividend[gnt_idx*DW +: DW];
    assign sel_b     = req_divisor[gnt_idx*DW +: DW];

    // The divider's own error flag is not needed: screening happens at accept.
    Divider32bit u_div (
        .a   (op_a),
        .b   (op_b),
        .y   (div_y),
        .err (div_error_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr            <= '0;
            op_id         <= '0;
            cnt           <= '0;
            op_a          <= '0;
            op_b          <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        op_id <= gnt_idx;
                        cnt   <= '0;
                        rr    <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                        if (sel_b == '0) begin
                            rsp_id        <= gnt_idx;
                            rsp_quotient  <= '0;
                            rsp_remainder <= '0;
                            rsp_error     <= 1'b1;
                            state         <= RESP;
                        end else if (sel_a == MOST_NEG && sel_b == MINUS_ONE) begin
                            rsp_id        <= gnt_idx;
                            rsp_quotient  <= MOST_NEG;
                            rsp_remainder <= '0;
                            rsp_error     <= 1'b1;
                            state         <= RESP;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == CW'(LAT-1)) begin
                        rsp_id        <= op_id;
                        rsp_quotient  <= div_y[DW-1:0];
                        rsp_remainder <= div_y[2*DW-1:DW];
                        rsp_error     <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    // Screened results arrive with rsp_valid low; raise it one
                    // cycle later so they appear one cycle after accept.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
module tb_div_share_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_dividend;
    logic [63:0] req_divisor;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_quotient;
    logic [31:0] rsp_remainder;
    logic        rsp_error;

    int n_checks = 0;
    int n_fail   = 0;

    div_share_ctrl #(.NREQ(2), .LAT(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_error     (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_dividend[i*32 +: 32] = a;
        req_divisor[i*32 +: 32]  = b;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Steps cycles until rsp_valid is seen; cyc = edges after the accept edge.
    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < max) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #2;
        n_checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 ||
            rsp_quotient !== 32'd0 || rsp_remainder !== 32'd0 || rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b valid=%b id=%0d q=%h r=%h err=%b, want all zero",
                     req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        int cyc;
        do_reset();
        set_req(0, -7, 2);
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant: got %b want 01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        n_checks++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL single_ready_busy: got %b want 00", req_ready);
        end
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 2 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles valid=%b want 2 cycles", cyc, rsp_valid);
        end
        n_checks++;
        if (rsp_quotient !== 32'hFFFF_FFFD || rsp_remainder !== 32'hFFFF_FFFF ||
            rsp_error !== 1'b0 || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got q=%h r=%h err=%b id=%0d want q=fffffffd r=ffffffff err=0 id=0",
                     rsp_quotient, rsp_remainder, rsp_error, rsp_id);
        end
        handshake();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: got valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [0:0]  exp_id [3];
        logic [31:0] exp_q  [3];
        logic [31:0] exp_r  [3];
        int          exp_c  [3];
        int          got;
        int          cyc;
        exp_id = '{1'b0, 1'b1, 1'b0};
        exp_q  = '{32'hFFFF_FFFA, 32'd6, 32'hFFFF_FFFA};
        exp_r  = '{32'd2, 32'hFFFF_FFFE, 32'd2};
        exp_c  = '{3, 7, 11};
        do_reset();
        set_req(0, 20, -3);
        set_req(1, -20, -3);
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rsp_valid === 1'b1) begin
                n_checks++;
                if (rsp_id !== exp_id[got] || rsp_quotient !== exp_q[got] ||
                    rsp_remainder !== exp_r[got] || rsp_error !== 1'b0 || cyc !== exp_c[got]) begin
                    n_fail++;
                    $display("FAIL rr_resp%0d: got id=%0d q=%h r=%h err=%b cyc=%0d want id=%0d q=%h r=%h err=0 cyc=%0d",
                             got, rsp_id, rsp_quotient, rsp_remainder, rsp_error, cyc,
                             exp_id[got], exp_q[got], exp_r[got], exp_c[got]);
                end
                got++;
                if (got == 3) req_valid = 2'b00;
            end
        end
        n_checks++;
        if (got !== 3) begin
            n_fail++;
            $display("FAIL rr_count: got %0d responses want 3", got);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_div_zero();
        int cyc;
        do_reset();
        set_req(0, -5, 0);
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 1 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_latency: got %0d cycles valid=%b want 1 cycle", cyc, rsp_valid);
        end
        n_checks++;
        if (rsp_error !== 1'b1 || rsp_quotient !== 32'd0 || rsp_remainder !== 32'd0 || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL div0_result: got err=%b q=%h r=%h id=%0d want err=1 q=0 r=0 id=0",
                     rsp_error, rsp_quotient, rsp_remainder, rsp_id);
        end
        handshake();
    endtask

    task automatic test_overflow();
        int cyc;
        do_reset();
        set_req(1, 32'h8000_0000, 32'hFFFF_FFFF);
        req_valid = 2'b10;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL ovf_grant: got %b want 10", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 1 || rsp_error !== 1'b1 || rsp_quotient !== 32'h8000_0000 ||
            rsp_remainder !== 32'd0 || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_result: got cyc=%0d err=%b q=%h r=%h id=%0d want cyc=1 err=1 q=80000000 r=0 id=1",
                     cyc, rsp_error, rsp_quotient, rsp_remainder, rsp_id);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int cyc;
        int extra;
        do_reset();
        set_req(0, -3, -2);
        set_req(1, 40, 5);
        req_valid = 2'b11;
        @(posedge clk);
        #1;
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 2 || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d cycles valid=%b want 2", cyc, rsp_valid);
        end
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_quotient !== 32'd1 || rsp_remainder !== 32'hFFFF_FFFF ||
                rsp_error !== 1'b0 || rsp_id !== 1'b0 || req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got valid=%b q=%h r=%h err=%b id=%0d ready=%b want 1/00000001/ffffffff/0/0/00",
                         i, rsp_valid, rsp_quotient, rsp_remainder, rsp_error, rsp_id, req_ready);
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        req_valid = 2'b00;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid === 1'b1) extra++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL bp_single_delivery: got %0d extra valid cycles want 0", extra);
        end
    endtask

    task automatic test_reset_busy();
        int cyc;
        do_reset();
        set_req(0, 9, 2);
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_valid(20, cyc);
        handshake();
        set_req(0, 50, 3);
        req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        reset     = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 ||
            rsp_quotient !== 32'd0 || rsp_remainder !== 32'd0 || rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL rstbusy_outputs: got ready=%b valid=%b id=%0d q=%h r=%h err=%b want all zero",
                     req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error);
        end
        set_req(0, 100, 7);
        set_req(1, -100, 7);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL rstbusy_grant: got %b want 01", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_valid(20, cyc);
        n_checks++;
        if (cyc !== 2 || rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_quotient !== 32'd14 ||
            rsp_remainder !== 32'd2 || rsp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL rstbusy_result: got cyc=%0d valid=%b id=%0d q=%h r=%h err=%b want cyc=2 valid=1 id=0 q=0000000e r=00000002 err=0",
                     cyc, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_error);
        end
        handshake();
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
